// File: rtl/dpram_pkg.sv
// Shared constants and the byte-lane merge helper for the byte-enable dual-port RAM.
// byte_merge works on a wide word so every instance width can share one function.
package dpram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE   = 2;

  localparam int MAX_DATA_WIDTH = 512;
  localparam int MAX_IDX_W      = $clog2(MAX_DATA_WIDTH);

  typedef logic [MAX_DATA_WIDTH-1:0] wide_word_t;

  // be carries one bit per lane in its low bits; lanes with be=1 take new_word.
  function automatic wide_word_t byte_merge(input wide_word_t old_word,
                                            input wide_word_t new_word,
                                            input wide_word_t be,
                                            input int         byte_width);
    wide_word_t merged;
    merged = old_word;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (be[MAX_IDX_W'(i / byte_width)]) begin
        merged[MAX_IDX_W'(i)] = new_word[MAX_IDX_W'(i)];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dpram_port_pipe.sv
// Per-port read pipeline: stage-1 captures read data at the access edge, an
// optional stage-2 delays it by one more edge when READ_LATENCY is 2.
module dpram_port_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid
);

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d;

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = load;
    if (load) begin
      s1_data_d = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s2_valid_q, s2_valid_d;

    // Stage-2 only moves on a valid beat so dout holds between reads.
    always_comb begin
      s2_data_d  = s2_data_q;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s2_valid_d;
      end
    end

    assign dout       = s2_data_q;
    assign dout_valid = s2_valid_q;
  end else begin : g_lat1
    assign dout       = s1_data_q;
    assign dout_valid = s1_valid_q;
  end

endmodule

// File: rtl/dpram_be_pipe.sv
// Single-clock true dual-port RAM with byte enables, per-port read-during-write
// modes, 1/2-cycle read latency, range checking and cross-port collision tracking.
module dpram_be_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int NUM_BYTES    = DATA_WIDTH / BYTE_WIDTH,
  parameter int DEPTH        = 1024,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int RDW_MODE_A   = RDW_WRITE_FIRST,
  parameter int RDW_MODE_B   = RDW_WRITE_FIRST,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic [NUM_BYTES-1:0]  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  dout_valid_a,
  output logic                  err_a,
  input  logic                  en_b,
  input  logic [NUM_BYTES-1:0]  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dout_valid_b,
  output logic                  err_b,
  output logic                  coll_ww,
  output logic                  coll_rw,
  output logic [15:0]           coll_cnt,
  input  logic                  coll_clr
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic                  in_range_a, in_range_b;
  logic                  wr_a, wr_b;
  logic                  wr_en_a, wr_en_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] merged_a, merged_b;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  logic                  load_a, load_b;
  logic                  same_addr;

  logic        err_a_q, err_a_d, err_b_q, err_b_d;
  logic        coll_ww_q, coll_ww_d, coll_rw_q, coll_rw_d;
  logic [15:0] coll_cnt_q, coll_cnt_d;

  assign in_range_a = ({1'b0, addr_a} < DEPTH_L);
  assign in_range_b = ({1'b0, addr_b} < DEPTH_L);
  assign wr_a       = |we_a;
  assign wr_b       = |we_b;
  assign wr_en_a    = en_a && wr_a && in_range_a;
  assign wr_en_b    = en_b && wr_b && in_range_b;

  // One narrow array per lane; B is written first so A wins on shared lanes.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en_b && we_b[gi]) begin
        lane_mem[addr_b] <= din_b[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (wr_en_a && we_a[gi]) begin
        lane_mem[addr_a] <= din_a[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    assign old_a[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[addr_a];
    assign old_b[gi*BYTE_WIDTH +: BYTE_WIDTH] = lane_mem[addr_b];
  end

  assign merged_a = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_a), MAX_DATA_WIDTH'(din_a),
                                           MAX_DATA_WIDTH'(we_a), BYTE_WIDTH));
  assign merged_b = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_b), MAX_DATA_WIDTH'(din_b),
                                           MAX_DATA_WIDTH'(we_b), BYTE_WIDTH));

  // The other port's same-edge write is never visible here: cross-port read-first.
  always_comb begin
    rd_data_a = '0;
    load_a    = en_a && !(wr_a && (RDW_MODE_A == RDW_NO_CHANGE));
    if (in_range_a) begin
      rd_data_a = (!wr_a || RDW_MODE_A == RDW_READ_FIRST) ? old_a : merged_a;
    end
  end

  always_comb begin
    rd_data_b = '0;
    load_b    = en_b && !(wr_b && (RDW_MODE_B == RDW_NO_CHANGE));
    if (in_range_b) begin
      rd_data_b = (!wr_b || RDW_MODE_B == RDW_READ_FIRST) ? old_b : merged_b;
    end
  end

  dpram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_a),
    .load_data (rd_data_a),
    .dout      (dout_a),
    .dout_valid(dout_valid_a)
  );

  dpram_port_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_b),
    .load_data (rd_data_b),
    .dout      (dout_b),
    .dout_valid(dout_valid_b)
  );

  assign same_addr = en_a && en_b && in_range_a && in_range_b && (addr_a == addr_b);

  always_comb begin
    err_a_d    = en_a && !in_range_a;
    err_b_d    = en_b && !in_range_b;
    coll_ww_d  = same_addr && wr_a && wr_b;
    coll_rw_d  = same_addr && (wr_a != wr_b);
    coll_cnt_d = coll_cnt_q;
    if (coll_clr) begin
      coll_cnt_d = '0;
    end else if ((coll_ww_d || coll_rw_d) && coll_cnt_q != 16'hFFFF) begin
      coll_cnt_d = coll_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_a_q    <= 1'b0;
      err_b_q    <= 1'b0;
      coll_ww_q  <= 1'b0;
      coll_rw_q  <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      err_a_q    <= err_a_d;
      err_b_q    <= err_b_d;
      coll_ww_q  <= coll_ww_d;
      coll_rw_q  <= coll_rw_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign err_a    = err_a_q;
  assign err_b    = err_b_q;
  assign coll_ww  = coll_ww_q;
  assign coll_rw  = coll_rw_q;
  assign coll_cnt = coll_cnt_q;

endmodule

// File: doc/dpram_be_pipe.md
Name: dpram_be_pipe

Overview:
- Parameterised single-clock true dual-port RAM, successor to the team's basic dual-port RAM.
- Adds per-byte write enables, per-port port enables and a per-port read-during-write mode (READ_FIRST, WRITE_FIRST or NO_CHANGE).
- Adds a selectable read latency of 1 or 2 cycles with read-valid outputs, deterministic cross-port collision handling, and address range checking.
- Sits under the FIFO and shared-buffer blocks as their common storage primitive.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, width of one write-enable lane.
- NUM_BYTES, DATA_WIDTH/BYTE_WIDTH, number of write-enable lanes (derived).
- DEPTH, 1024, number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), address width (derived).
- RDW_MODE_A, 1, port A read-during-write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- RDW_MODE_B, 1, port B read-during-write mode, same encoding.
- READ_LATENCY, 1, edges from access to dout; legal values 1 or 2.

Ports:
- clk, input, 1, single clock for both ports.
- rst_n, input, 1, reset, asynchronous, active-low.
- en_a, input, 1, port A access enable.
- we_a, input, NUM_BYTES, port A byte write enables; nonzero = write, zero = read.
- addr_a, input, ADDR_WIDTH, port A word address.
- din_a, input, DATA_WIDTH, port A write data.
- dout_a, output, DATA_WIDTH, port A read data.
- dout_valid_a, output, 1, dout_a was updated this cycle.
- err_a, output, 1, one-cycle pulse: port A addressed a location >= DEPTH.
- en_b, we_b, addr_b, din_b, dout_b, dout_valid_b, err_b: port B, identical to port A.
- coll_ww, output, 1, one-cycle pulse: both ports wrote the same address.
- coll_rw, output, 1, one-cycle pulse: one port read an address the other port wrote.
- coll_cnt, output, 16, saturating count of collision events.
- coll_clr, input, 1, synchronous clear of coll_cnt.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dout_a, dout_b, all pipeline registers and coll_cnt clear to 0.
  - dout_valid_*, err_*, coll_ww and coll_rw clear to 0.
  - Memory array is not reset.
  - Accesses in flight are discarded; no valid is asserted for them after release.
- Access:
  - An access happens at a rising edge when en_x=1.
  - en_x=0: no memory change; stage-1 data holds; the valid pipeline shifts in 0.
- Write (we_x != 0): only the byte lanes with we_x[i]=1 are updated.
- Read data per mode:
  - Read: stage-1 data = mem[addr].
  - Write, READ_FIRST: stage-1 data = old word.
  - Write, WRITE_FIRST: stage-1 data = merged word (new enabled lanes, old lanes elsewhere).
  - Write, NO_CHANGE: stage-1 data holds and no valid is generated.
- Latency:
  - READ_LATENCY=1: dout_x and dout_valid_x update at the access edge.
  - READ_LATENCY=2: they update one edge later; back-to-back accesses are fully pipelined, one per cycle.
  - dout_x holds its last value whenever dout_valid_x=0.
- Range check, address >= DEPTH:
  - Write is ignored; read data is 0.
  - Valid follows the normal rules.
  - err_x pulses in the cycle after the access edge.
- Collisions (same address, same edge, both en=1):
  - Both write: for lanes written by both ports, port A data is stored; lanes written by one port only keep that port's data.
  - coll_ww pulses in the next cycle.
  - Write on one port, read on the other: the reader gets the old word (cross-port read-first); coll_rw pulses in the next cycle.
  - Both read: no flag.
  - Out-of-range addresses never raise a collision.
- coll_cnt:
  - Increments by 1 per edge where coll_ww or coll_rw is generated.
  - Saturates at 16'hFFFF.
  - coll_clr has priority over the increment.

Decomposition:
- dpram_pkg: RDW_READ_FIRST, RDW_WRITE_FIRST and RDW_NO_CHANGE constants, plus the function byte_merge(old, new, be).
- dpram_port_pipe: sub-module instantiated once per port; holds the stage-1/stage-2 data and valid registers, selected by READ_LATENCY.
- Top level contains the memory, the write-priority logic (port B write applied before port A in the same process), the collision/err logic and coll_cnt.

Test Plan:
- Reset mid-pipeline: READ_LATENCY=2, read issued, rst_n pulsed low before the second edge -> dout_a=0, dout_valid_a never asserts for that read.
- Byte merge: mem[5]=32'hAABBCCDD; port A writes 32'h11223344 with we_a=4'b0101, WRITE_FIRST -> dout_a=32'hAA22CC44 and a later read of address 5 returns the same.
- Read-during-write modes: mem[3]=32'h1, write 32'h2:
  - READ_FIRST -> dout=32'h1.
  - WRITE_FIRST -> dout=32'h2.
  - NO_CHANGE -> dout holds its previous value, valid stays 0.
- Write-write collision at address 7: A writes 32'hA, B writes 32'hB, both we=4'hF -> mem[7]=32'hA, coll_ww pulses 1 cycle, coll_cnt=1.
- Read-write collision: mem[9]=32'h55; A reads 9 while B writes 32'h66 -> dout_a=32'h55, coll_rw pulses, next read of address 9 returns 32'h66.
- Range and saturation:
  - DEPTH=1000, access to address 1000 -> err pulses, memory unchanged, read returns 0.
  - coll_cnt preloaded to 16'hFFFF by 65535 collisions, one more collision -> stays 16'hFFFF.
  - coll_clr -> 0.
